// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants.
// Holds the EX/MEM field types, the enable encoding, the elastic-stage
// state encoding and the default EX2MEM payload widths. Optional stage
// feature macro: PIPE_STAGE_STALL_CNT_EN (consumed by pipe_stage_skid).
package pipe_pkg;

  typedef logic        enable_t;
  typedef logic [31:0] data_t;
  typedef logic [4:0]  reg_addr_t;
  typedef logic [1:0]  wb_data_sel_t;

  localparam enable_t ENABLE  = 1'b1;
  localparam enable_t DISABLE = 1'b0;

  // State of an elastic stage, derived from its two valid bits.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_t;

  // EX2MEM payload: alu result + write data + rd + wb select + pc_next.
  localparam int unsigned DATA_W_EX2MEM = $bits(data_t) + $bits(data_t) + $bits(reg_addr_t)
                                        + $bits(wb_data_sel_t) + $bits(data_t);
  // EX2MEM side effects: mem_write, reg_write.
  localparam int unsigned CTRL_W_EX2MEM = 2;

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating event counter for pipeline stall statistics.
// Ports:
//   ACLK    - clock, rising edge
//   ARESETn - asynchronous reset, active-low; clears the count
//   inc     - count this cycle
//   count   - current count, sticks at all-ones
module pipe_stall_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a one-entry skid slot and flush.
// Data bits and side-effect control bits are held separately; control is
// zeroed whenever the head is not valid so bubbles never cause writes.
// Optional feature: define PIPE_STAGE_STALL_CNT_EN to count cycles where
// the head is valid but blocked (saturating); otherwise stall_cycles_o = 0.
// Ports:
//   ACLK, ARESETn   - clock (rising) and async active-low reset
//   flush_i         - synchronous kill of all held entries
//   in_valid_i/in_ready_o, in_data_i/in_ctrl_i     - upstream handshake
//   out_valid_o/out_ready_i, out_data_o/out_ctrl_o - downstream handshake
//   stall_cycles_o  - stall cycle count
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_EX2MEM,
  parameter int unsigned CTRL_W      = CTRL_W_EX2MEM,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_W-1:0]      in_data_i,
  input  logic [CTRL_W-1:0]      in_ctrl_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_W-1:0]      out_data_o,
  output logic [CTRL_W-1:0]      out_ctrl_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;

  skid_state_t state;
  logic        accept;
  logic        emit;

  always_comb begin
    if (skid_valid_q) begin
      state = SKID;
    end else if (main_valid_q) begin
      state = FULL;
    end else begin
      state = EMPTY;
    end
  end

  // in_ready_o is a pure register output: no path from out_ready_i.
  assign in_ready_o = ~skid_valid_q;
  assign accept     = in_valid_i & in_ready_o;
  assign emit       = main_valid_q & out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;

    if (flush_i) begin
      // Any emit this cycle already happened at the port; the accept is dropped.
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data_i;
            main_ctrl_d  = in_ctrl_i;
          end
        end
        FULL: begin
          if (accept && out_ready_i) begin
            main_data_d = in_data_i;
            main_ctrl_d = in_ctrl_i;
          end else if (accept) begin
            // Head is blocked: park the new entry behind it.
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
            skid_ctrl_d  = in_ctrl_i;
          end else if (emit) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
          end
        end
        SKID: begin
          if (emit) begin
            main_data_d  = skid_data_q;
            main_ctrl_d  = skid_ctrl_q;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
          end
        end
        default: begin
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
    end
  end

  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;
  assign out_ctrl_o  = main_valid_q ? main_ctrl_q : '0;

`ifdef PIPE_STAGE_STALL_CNT_EN
  pipe_stall_counter #(
    .WIDTH(STALL_CNT_W)
  ) u_stall_counter (
    .ACLK   (ACLK),
    .ARESETn(ARESETn),
    .inc    (main_valid_q & ~out_ready_i),
    .count  (stall_cycles_o)
  );
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (STALL_CNT_W = 4).
// Stall-counter expectations follow PIPE_STAGE_STALL_CNT_EN.
module tb_pipe_stage_skid;

  localparam int unsigned DataW  = 103;
  localparam int unsigned CtrlW  = 2;
  localparam int unsigned StallW = 4;

`ifdef PIPE_STAGE_STALL_CNT_EN
  localparam int unsigned ExpStall5   = 5;
  localparam int unsigned ExpStallSat = 15;
`else
  localparam int unsigned ExpStall5   = 0;
  localparam int unsigned ExpStallSat = 0;
`endif

  logic              ACLK;
  logic              ARESETn;
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DataW-1:0]  in_data_i;
  logic [CtrlW-1:0]  in_ctrl_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DataW-1:0]  out_data_o;
  logic [CtrlW-1:0]  out_ctrl_o;
  logic [StallW-1:0] stall_cycles_o;

  int unsigned n_vec;
  int unsigned n_bad;

  pipe_stage_skid #(
    .DATA_W     (DataW),
    .CTRL_W     (CtrlW),
    .STALL_CNT_W(StallW)
  ) dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_data_i     (in_data_i),
    .in_ctrl_i     (in_ctrl_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .out_ctrl_o    (out_ctrl_o),
    .stall_cycles_o(stall_cycles_o)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push(input logic [DataW-1:0] d, input logic [CtrlW-1:0] c);
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_ctrl_i  = c;
    step();
    in_valid_i = 1'b0;
  endtask

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    ARESETn     = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = DataW'('h5A);
    in_ctrl_i   = 2'b11;
    out_ready_i = 1'b0;

    // Reset holds the stage empty even with a valid input present.
    step();
    step();
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_out_ctrl", out_ctrl_o, 2'b00);
    check("rst_in_ready", in_ready_o, 1'b1);
    check("rst_stall", stall_cycles_o, 4'd0);

    in_data_i = DataW'('h1);
    ARESETn   = 1'b1;
    step();
    in_valid_i = 1'b0;
    check("first_valid", out_valid_o, 1'b1);
    check("first_data", out_data_o, DataW'('h1));
    check("first_ctrl", out_ctrl_o, 2'b11);
    out_ready_i = 1'b1;
    step();
    check("first_drain", out_valid_o, 1'b0);

    // Back-to-back streaming.
    for (int i = 0; i < 8; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = DataW'(32'h10 + i);
      in_ctrl_i  = 2'b10;
      step();
      check($sformatf("stream_valid_%0d", i), out_valid_o, 1'b1);
      check($sformatf("stream_data_%0d", i), out_data_o, DataW'(32'h10 + i));
      check($sformatf("stream_ready_%0d", i), in_ready_o, 1'b1);
    end
    in_valid_i = 1'b0;
    step();
    check("stream_end", out_valid_o, 1'b0);

    // Skid: two pushes into a blocked stage.
    out_ready_i = 1'b0;
    push(DataW'('hA), 2'b01);
    check("skid_full_ready", in_ready_o, 1'b1);
    push(DataW'('hB), 2'b10);
    check("skid_ready_low", in_ready_o, 1'b0);
    check("skid_head", out_data_o, DataW'('hA));
    step();
    check("skid_hold_data", out_data_o, DataW'('hA));
    check("skid_hold_ctrl", out_ctrl_o, 2'b01);
    check("skid_hold_ready", in_ready_o, 1'b0);
    out_ready_i = 1'b1;
    #1;
    check("skid_emit_a", out_data_o, DataW'('hA));
    step();
    check("skid_emit_b_valid", out_valid_o, 1'b1);
    check("skid_emit_b", out_data_o, DataW'('hB));
    check("skid_emit_b_ctrl", out_ctrl_o, 2'b10);
    check("skid_ready_back", in_ready_o, 1'b1);
    step();
    check("skid_drained", out_valid_o, 1'b0);

    // Flush in SKID with a simultaneous push that must be dropped.
    out_ready_i = 1'b0;
    push(DataW'('hA), 2'b01);
    push(DataW'('hB), 2'b01);
    check("flush_pre_skid", in_ready_o, 1'b0);
    flush_i    = 1'b1;
    in_valid_i = 1'b1;
    in_data_i  = DataW'('hC);
    in_ctrl_i  = 2'b11;
    step();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check("flush_valid", out_valid_o, 1'b0);
    check("flush_ctrl", out_ctrl_o, 2'b00);
    check("flush_ready", in_ready_o, 1'b1);
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("flush_no_c_%0d", i), out_valid_o, 1'b0);
    end

    // Bubbles with live control on the input never reach out_ctrl_o.
    out_ready_i = 1'b0;
    in_ctrl_i   = 2'b11;
    in_data_i   = DataW'('h77);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("bubble_valid_%0d", i), out_valid_o, 1'b0);
      check($sformatf("bubble_ctrl_%0d", i), out_ctrl_o, 2'b00);
    end

    // Stall counter: fresh reset, then block a valid head.
    ARESETn = 1'b0;
    #1;
    check("cnt_rst_async_valid", out_valid_o, 1'b0);
    check("cnt_rst", stall_cycles_o, 4'd0);
    ARESETn = 1'b1;
    push(DataW'('h1), 2'b11);
    for (int i = 0; i < 5; i++) step();
    check("cnt_5", stall_cycles_o, StallW'(ExpStall5));
    for (int i = 0; i < 15; i++) step();
    check("cnt_sat", stall_cycles_o, StallW'(ExpStallSat));
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    step();
    check("cnt_after_flush", stall_cycles_o, StallW'(ExpStallSat));
    check("cnt_flush_empty", out_valid_o, 1'b0);
    ARESETn = 1'b0;
    #1;
    check("cnt_cleared", stall_cycles_o, 4'd0);
    ARESETn = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
